// File: rtl/mul4_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated 4-operand multiplier.
package mul4_arb_pkg;

  localparam int DW_DEF      = 10;
  localparam int NUM_REQ_DEF = 4;
  localparam int PW          = 2 * DW_DEF;
  localparam int RW          = 4 * DW_DEF;

  typedef struct packed {
    logic [DW_DEF-1:0] a;
    logic [DW_DEF-1:0] b;
    logic [DW_DEF-1:0] c;
    logic [DW_DEF-1:0] d;
  } operand_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul4_pipe.sv
// Stall-able two-stage a*b*c*d multiplier: pairwise products, then the final product.
module mul4_pipe #(
  parameter int DW   = 10,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [DW-1:0]   c,
  input  logic [DW-1:0]   d,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic [4*DW-1:0] out_prod
);

  localparam int PWL = 2 * DW;
  localparam int RWL = 4 * DW;

  logic            s1_valid_q, s1_valid_d;
  logic [PWL-1:0]  p0_q, p0_d;
  logic [PWL-1:0]  p1_q, p1_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [RWL-1:0]  s2_prod_q, s2_prod_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_id_d    = s2_id_q;
    if (en) begin
      s1_valid_d = in_valid;
      p0_d       = PWL'(a) * PWL'(b);
      p1_d       = PWL'(c) * PWL'(d);
      s1_id_d    = in_id;
      s2_valid_d = s1_valid_q;
      s2_prod_d  = RWL'(p0_q) * RWL'(p1_q);
      s2_id_d    = s1_id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p0_q       <= '0;
      p1_q       <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_id    = s2_id_q;
  assign out_prod  = s2_prod_q;

endmodule

// File: rtl/mul4_arbiter.sv
// Round-robin arbiter sharing one mul4_pipe among NUM_REQ requesters.
// Define MUL4_ARB_PRIO0_EN to give requester 0 strict priority.
module mul4_arbiter
  import mul4_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int ID_W    = clog2((NUM_REQ > 2) ? NUM_REQ : 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*4*DW-1:0]   req_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [4*DW-1:0]           res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  localparam int OW = 4 * DW;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               s1_busy_q, s1_busy_d;
  logic [ID_W-1:0]    gnt_idx;
  logic               found;
  logic [NUM_REQ-1:0] rot;
  logic               any_req;
  logic               advance;
  logic               transfer;
  logic               rr_upd;
  logic [OW-1:0]      ops;
  int unsigned        j;

  assign any_req = |req_valid;
  assign advance = !res_valid || res_ready;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    rot     = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      rot = req_valid >> j;
      if (!found && rot[0]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
`ifdef MUL4_ARB_PRIO0_EN
    if (req_valid[0]) gnt_idx = '0;
`endif
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && advance && any_req && (gnt_idx == ID_W'(i));
    end
  end

  assign transfer = |(req_valid & req_ready);

`ifdef MUL4_ARB_PRIO0_EN
  // A priority grant to requester 0 leaves the rotation untouched.
  assign rr_upd = transfer && !req_valid[0];
`else
  assign rr_upd = transfer;
`endif

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    s1_busy_d = s1_busy_q;
    if (rr_upd) begin
      rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
    if (advance) s1_busy_d = transfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      s1_busy_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      s1_busy_q <= s1_busy_d;
    end
  end

  always_comb begin
    ops = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) ops = req_data[i*OW +: OW];
    end
  end

  mul4_pipe #(
    .DW   (DW),
    .ID_W (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .in_valid  (transfer),
    .in_id     (gnt_idx),
    .a         (ops[4*DW-1 -: DW]),
    .b         (ops[3*DW-1 -: DW]),
    .c         (ops[2*DW-1 -: DW]),
    .d         (ops[DW-1 -: DW]),
    .out_valid (res_valid),
    .out_id    (res_id),
    .out_prod  (res_data)
  );

  assign busy = s1_busy_q || res_valid;

endmodule
